// File: rtl/dc_useq.sv
// ----------------------------------------------------------------------------
// dc_useq -- microcode sequencer with a circular return stack.
//
// Computes the next microaddress from the microcode ROM word (ma_in / mc_in),
// registers it together with the AX extension bit, and presents it as a_out.
// Supports NEXT, conditional branch, CALL/RET through a small return stack,
// instruction-decode dispatch and a level-sensitive trap.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   hold      in   1   stall; freezes all sequencer state
//   ax        in   1   AX extension line, registered into a_out[9]
//   ma_in     in   9   next-address field from ROM
//   mc_in     in  16   ROM opcode ([15:13] op, [12:10] condition select)
//   cond      in   8   branch condition vector
//   pla_addr  in   9   dispatch address
//   trap_req  in   1   trap request
//   a_out     out 10   ROM address {ax_q, addr_q}
//   cen_out   out  1   ROM clock enable (~hold)
//   mc_out    out 16   registered executing opcode
//   mc_vld    out  1   mc_out valid
//   trap_ack  out  1   one-cycle pulse when a trap is taken
//   stk_err   out  1   sticky return-stack overflow/underflow flag
// ----------------------------------------------------------------------------
module dc_useq #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [8:0]  RESET_ADDR  = 9'h000,
    parameter logic [8:0]  TRAP_ADDR   = 9'h008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        ax,
    input  logic [8:0]  ma_in,
    input  logic [15:0] mc_in,
    input  logic [7:0]  cond,
    input  logic [8:0]  pla_addr,
    input  logic        trap_req,
    output logic [9:0]  a_out,
    output logic        cen_out,
    output logic [15:0] mc_out,
    output logic        mc_vld,
    output logic        trap_ack,
    output logic        stk_err
);

    localparam int unsigned AW    = 9;
    localparam int unsigned MW    = 16;
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_BRC  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_DISP = 3'b100;

    // Sequencer state
    logic [AW-1:0]    r_addr;
    logic             r_ax;
    logic [AW-1:0]    r_stack [STACK_DEPTH];
    logic [PTR_W-1:0] r_wp;      // next slot to write; top of stack is r_wp-1
    logic [CNT_W-1:0] r_cnt;
    logic [MW-1:0]    r_mc;
    logic             r_vld;
    logic             r_ack;
    logic             r_err;
    logic             r_first;   // no unheld edge seen since reset

    // Decode / next-address wires
    logic [2:0]       w_op;
    logic [2:0]       w_sel;
    logic [AW-1:0]    w_next_addr;
    logic [AW-1:0]    w_link;
    logic [AW-1:0]    w_ret_addr;
    logic [PTR_W-1:0] w_wp_dec;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_set_err;

    assign w_op       = mc_in[15:13];
    assign w_sel      = mc_in[12:10];
    assign w_link     = AW'(ma_in + AW'(1));
    assign w_wp_dec   = PTR_W'(r_wp - PTR_W'(1));
    assign w_ret_addr = r_stack[w_wp_dec];
    assign w_full     = (r_cnt == CNT_W'(STACK_DEPTH));
    assign w_empty    = (r_cnt == '0);

    // Next-address selection; a trap overrides the opcode and leaves the stack alone
    always_comb begin
        w_next_addr = ma_in;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_err   = 1'b0;
        if (trap_req) begin
            w_next_addr = TRAP_ADDR;
        end else begin
            case (w_op)
                OP_BRC: begin
                    w_next_addr = {ma_in[8:1], ma_in[0] | cond[w_sel]};
                end
                OP_CALL: begin
                    w_push      = 1'b1;
                    w_set_err   = w_full;
                    w_next_addr = ma_in;
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_set_err   = 1'b1;
                        w_next_addr = RESET_ADDR;
                    end else begin
                        w_pop       = 1'b1;
                        w_next_addr = w_ret_addr;
                    end
                end
                OP_DISP: begin
                    w_next_addr = pla_addr;
                end
                default: begin
                    w_next_addr = ma_in;
                end
            endcase
        end
    end

    // Sequencer registers; everything freezes while hold is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= RESET_ADDR;
            r_ax    <= 1'b0;
            r_wp    <= '0;
            r_cnt   <= '0;
            r_mc    <= '0;
            r_vld   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b1;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (!hold) begin
            r_addr  <= w_next_addr;
            r_ax    <= ax;
            r_first <= 1'b0;
            r_ack   <= trap_req;
            if (trap_req) begin
                r_vld <= 1'b0;
            end else begin
                r_mc  <= mc_in;
                r_vld <= ~r_first;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            // Full stack: the write slot is the oldest entry, so it is overwritten
            if (w_push) begin
                r_stack[r_wp] <= w_link;
                r_wp          <= PTR_W'(r_wp + PTR_W'(1));
                if (!w_full) begin
                    r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
                end
            end
            if (w_pop) begin
                r_wp  <= w_wp_dec;
                r_cnt <= CNT_W'(r_cnt - CNT_W'(1));
            end
        end else begin
            r_ack <= 1'b0;
        end
    end

    assign a_out    = {r_ax, r_addr};
    assign cen_out  = ~hold;
    assign mc_out   = r_mc;
    assign mc_vld   = r_vld;
    assign trap_ack = r_ack;
    assign stk_err  = r_err;

endmodule

// File: tb/tb_dc_useq.sv
// ----------------------------------------------------------------------------
// tb_dc_useq -- self-checking bench for dc_useq.
// Directed scenarios check fixed expected values; a randomized run compares
// every output against a queue-based behavioural model of the sequencer.
// ----------------------------------------------------------------------------
module tb_dc_useq;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        ax;
    logic [8:0]  ma_in;
    logic [15:0] mc_in;
    logic [7:0]  cond;
    logic [8:0]  pla_addr;
    logic        trap_req;
    logic [9:0]  a_out;
    logic        cen_out;
    logic [15:0] mc_out;
    logic        mc_vld;
    logic        trap_ack;
    logic        stk_err;

    int errors = 0;
    int checks = 0;

    localparam int unsigned DEPTH = 4;

    // Behavioural model state
    logic [8:0]  m_addr;
    logic        m_ax;
    logic [8:0]  m_stk [$];
    logic [15:0] m_mc;
    logic        m_vld;
    logic        m_ack;
    logic        m_err;
    logic        m_first;

    dc_useq #(
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (9'h000),
        .TRAP_ADDR   (9'h008)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .ax       (ax),
        .ma_in    (ma_in),
        .mc_in    (mc_in),
        .cond     (cond),
        .pla_addr (pla_addr),
        .trap_req (trap_req),
        .a_out    (a_out),
        .cen_out  (cen_out),
        .mc_out   (mc_out),
        .mc_vld   (mc_vld),
        .trap_ack (trap_ack),
        .stk_err  (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_addr  = 9'h000;
        m_ax    = 1'b0;
        m_stk.delete();
        m_mc    = 16'h0000;
        m_vld   = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_first = 1'b1;
    endtask

    // One rising edge of the sequencer, from the rules for each op
    task automatic model_edge();
        logic [2:0] op;
        logic [2:0] sel;
        if (hold) begin
            m_ack = 1'b0;
        end else begin
            op    = mc_in[15:13];
            sel   = mc_in[12:10];
            m_ack = trap_req;
            m_ax  = ax;
            if (trap_req) begin
                m_addr = 9'h008;
                m_vld  = 1'b0;
            end else begin
                m_mc  = mc_in;
                m_vld = !m_first;
                if (op == 3'd1) begin
                    m_addr = ma_in | 9'(cond[sel]);
                end else if (op == 3'd2) begin
                    m_stk.push_back(9'(ma_in + 9'd1));
                    if (m_stk.size() > DEPTH) begin
                        m_stk.delete(0);
                        m_err = 1'b1;
                    end
                    m_addr = ma_in;
                end else if (op == 3'd3) begin
                    if (m_stk.size() == 0) begin
                        m_addr = 9'h000;
                        m_err  = 1'b1;
                    end else begin
                        m_addr = m_stk.pop_back();
                    end
                end else if (op == 3'd4) begin
                    m_addr = pla_addr;
                end else begin
                    m_addr = ma_in;
                end
            end
            m_first = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [2:0] sel, input logic [8:0] ma);
        mc_in = {op, sel, 10'($urandom)};
        ma_in = ma;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (a_out !== 10'h000) begin errors++; $display("FAIL reset_a_out got=%h exp=%h", a_out, 10'h000); end
        checks++;
        if (mc_vld !== 1'b0 || trap_ack !== 1'b0 || stk_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got vld=%b ack=%b err=%b exp 0 0 0", mc_vld, trap_ack, stk_err);
        end
        checks++;
        if (mc_out !== 16'h0000) begin errors++; $display("FAIL reset_mc_out got=%h exp=0000", mc_out); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        set_op(3'd0, 3'd0, 9'h010);
        step();
        checks++;
        if (a_out !== 10'h010) begin errors++; $display("FAIL first_a_out got=%h exp=010", a_out); end
        checks++;
        if (mc_vld !== 1'b0) begin errors++; $display("FAIL first_vld got=%b exp=0", mc_vld); end
        step();
        checks++;
        if (mc_vld !== 1'b1) begin errors++; $display("FAIL second_vld got=%b exp=1", mc_vld); end
        checks++;
        if (mc_out !== mc_in) begin errors++; $display("FAIL second_mc_out got=%h exp=%h", mc_out, mc_in); end
    endtask

    task automatic test_brc();
        set_op(3'd1, 3'd3, 9'h020);
        cond = 8'h08;
        step();
        checks++;
        if (a_out !== 10'h021) begin errors++; $display("FAIL brc_taken got=%h exp=021", a_out); end
        cond = 8'hF7;
        step();
        checks++;
        if (a_out !== 10'h020) begin errors++; $display("FAIL brc_not_taken got=%h exp=020", a_out); end
    endtask

    task automatic test_call_ret();
        logic [8:0] exp_ret [5];
        exp_ret[0] = 9'h105; exp_ret[1] = 9'h104; exp_ret[2] = 9'h103;
        exp_ret[3] = 9'h102; exp_ret[4] = 9'h000;
        do_reset();
        set_op(3'd0, 3'd0, 9'h000);
        step();
        for (int i = 0; i < 5; i++) begin
            set_op(3'd2, 3'd0, 9'(9'h100 + i));
            step();
            checks++;
            if (a_out !== {1'b0, 9'(9'h100 + i)}) begin
                errors++; $display("FAIL call%0d_a_out got=%h exp=%h", i, a_out, 9'(9'h100 + i));
            end
            checks++;
            if (stk_err !== (i == 4)) begin
                errors++; $display("FAIL call%0d_stk_err got=%b exp=%b", i, stk_err, (i == 4));
            end
        end
        for (int i = 0; i < 5; i++) begin
            set_op(3'd3, 3'd0, 9'h1FF);
            step();
            checks++;
            if (a_out !== {1'b0, exp_ret[i]}) begin
                errors++; $display("FAIL ret%0d_a_out got=%h exp=%h", i, a_out, exp_ret[i]);
            end
            checks++;
            if (stk_err !== 1'b1) begin errors++; $display("FAIL ret%0d_stk_err got=%b exp=1", i, stk_err); end
        end
    endtask

    task automatic test_trap();
        do_reset();
        set_op(3'd0, 3'd0, 9'h000);
        step();
        set_op(3'd2, 3'd0, 9'h050);
        step();
        set_op(3'd2, 3'd0, 9'h060);
        trap_req = 1'b1;
        step();
        checks++;
        if (a_out !== 10'h008) begin errors++; $display("FAIL trap_a_out got=%h exp=008", a_out); end
        checks++;
        if (trap_ack !== 1'b1 || mc_vld !== 1'b0) begin
            errors++; $display("FAIL trap_ack_vld got ack=%b vld=%b exp 1 0", trap_ack, mc_vld);
        end
        trap_req = 1'b0;
        set_op(3'd0, 3'd0, 9'h070);
        step();
        checks++;
        if (trap_ack !== 1'b0 || mc_vld !== 1'b1 || a_out !== 10'h070) begin
            errors++; $display("FAIL trap_after got ack=%b vld=%b a=%h exp 0 1 070", trap_ack, mc_vld, a_out);
        end
        set_op(3'd3, 3'd0, 9'h1FF);
        step();
        checks++;
        if (a_out !== 10'h051) begin errors++; $display("FAIL trap_ret1 got=%h exp=051", a_out); end
        step();
        checks++;
        if (a_out !== 10'h000 || stk_err !== 1'b1) begin
            errors++; $display("FAIL trap_ret2 got a=%h err=%b exp 000 1", a_out, stk_err);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_op(3'd0, 3'd0, 9'h033);
        step();
        set_op(3'd4, 3'd0, 9'h0AA);
        pla_addr = 9'h1A0;
        hold     = 1'b1;
        trap_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_out !== 10'h033 || cen_out !== 1'b0 || trap_ack !== 1'b0) begin
                errors++; $display("FAIL hold%0d got a=%h cen=%b ack=%b exp 033 0 0", i, a_out, cen_out, trap_ack);
            end
        end
        hold     = 1'b0;
        trap_req = 1'b0;
        #1;
        checks++;
        if (cen_out !== 1'b1) begin errors++; $display("FAIL hold_cen_release got=%b exp=1", cen_out); end
        step();
        checks++;
        if (a_out !== 10'h1A0) begin errors++; $display("FAIL hold_disp got=%h exp=1A0", a_out); end
    endtask

    task automatic test_ax_async_reset();
        do_reset();
        set_op(3'd0, 3'd0, 9'h07F);
        ax = 1'b1;
        step();
        checks++;
        if (a_out !== 10'h27F) begin errors++; $display("FAIL ax_a_out got=%h exp=27F", a_out); end
        set_op(3'd2, 3'd0, 9'h040);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_out !== 10'h000 || mc_vld !== 1'b0) begin
            errors++; $display("FAIL async_reset got a=%h vld=%b exp 000 0", a_out, mc_vld);
        end
        ax = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mc_in    = 16'($urandom);
            ma_in    = 9'($urandom);
            cond     = 8'($urandom);
            pla_addr = 9'($urandom);
            ax       = 1'($urandom);
            hold     = ($urandom_range(0, 7) == 0);
            trap_req = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (a_out !== {m_ax, m_addr}) begin
                errors++; $display("FAIL rnd%0d_a_out got=%h exp=%h", n, a_out, {m_ax, m_addr});
            end
            checks++;
            if (mc_vld !== m_vld || trap_ack !== m_ack || stk_err !== m_err) begin
                errors++; $display("FAIL rnd%0d_flags got vld=%b ack=%b err=%b exp %b %b %b",
                                   n, mc_vld, trap_ack, stk_err, m_vld, m_ack, m_err);
            end
            checks++;
            if (mc_out !== m_mc) begin errors++; $display("FAIL rnd%0d_mc_out got=%h exp=%h", n, mc_out, m_mc); end
            checks++;
            if (cen_out !== ~hold) begin errors++; $display("FAIL rnd%0d_cen got=%b exp=%b", n, cen_out, ~hold); end
        end
        hold     = 1'b0;
        trap_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        hold     = 1'b0;
        ax       = 1'b0;
        ma_in    = '0;
        mc_in    = '0;
        cond     = '0;
        pla_addr = '0;
        trap_req = 1'b0;
        model_reset();
        test_reset();
        test_first_fetch();
        test_brc();
        test_call_ret();
        test_trap();
        test_hold();
        test_ax_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
